// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, beat struct and FSM state for the packet generator
package pc_pkg;
  localparam int DATA_W = 512;
  localparam int BYTES_PER_BEAT = 64;
  localparam int EMPTY_W = 6;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0] data;
  } pc_beat_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} pc_state_t;
endpackage

// File: rtl/pc_pkt_gen_if.sv
// pc_pkt_gen_if: 512-bit Avalon-ST packet bus with source and sink views
interface pc_pkt_gen_if;
  logic valid;
  logic ready;
  logic sop;
  logic eop;
  logic [pc_pkg::EMPTY_W-1:0] empty;
  logic [pc_pkg::DATA_W-1:0] data;
  modport master(output valid, sop, eop, empty, data, input ready);
  modport slave(input valid, sop, eop, empty, data, output ready);
endinterface

// File: rtl/pc_pkt_payload.sv
// pc_pkt_payload: self-describing beat pattern {pkt[15:0], beat[7:0], lane[7:0]} per 32-bit lane
module pc_pkt_payload import pc_pkg::*; (
  input  logic [15:0]       pkt_idx,
  input  logic [7:0]        beat_idx,
  output logic [DATA_W-1:0] data
);
  for (genvar i = 0; i < DATA_W / 32; i++) begin : g_lane
    assign data[DATA_W-1-32*i -: 32] = {pkt_idx, beat_idx, 8'(i)};
  end
endmodule

// File: rtl/pc_pkt_gen.sv
// pc_pkt_gen: Avalon-ST traffic generator emitting numbered packets with configurable length and gap
module pc_pkt_gen import pc_pkg::*; #(
  parameter int LEN_W   = 14,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 9600
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      cfg_num_pkts,
  input  logic [7:0]       cfg_gap,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pkt_cnt,
  pc_pkt_gen_if.master     tx
);
  localparam int BW = LEN_W - 6;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  pc_state_t st, st_n;
  logic [LEN_W-1:0] len_q, len_n, ln;
  logic [31:0] num_q, num_n, pkt_cnt_n, pkt_inc;
  logic [7:0] gap_q, gap_n, gap_cnt, gap_cnt_n;
  logic [BW-1:0] beat_q, beat_n, last;
  logic [15:0] np;
  logic done_n, stop_pend, stop_n, load, vld_q, vld_n;
  logic [DATA_W-1:0] pay;
  pc_beat_t q, q_n;
  // In IDLE the clamped config feeds the first beat directly; afterwards the latched length rules
  assign ln = st == IDLE ? (cfg_len < MIN_L ? MIN_L : cfg_len > MAX_L ? MAX_L : cfg_len) : len_q;
  assign last = BW'((ln - 1'b1) >> 6);
  assign pkt_inc = pkt_cnt + 32'd1;
  assign busy = st == SEND || st == GAP;
  assign tx.valid = vld_q;
  assign tx.sop = q.sop;
  assign tx.eop = q.eop;
  assign tx.empty = q.empty;
  assign tx.data = q.data;
  pc_pkt_payload u_payload (.pkt_idx(np), .beat_idx(8'(beat_n)), .data(pay));
  assign q_n = load ? '{sop: beat_n == '0, eop: beat_n == last,
                        empty: beat_n == last ? EMPTY_W'(BYTES_PER_BEAT - int'(ln[5:0])) : '0,
                        data: pay} : q;
  // Next-state: a new beat is loaded only after the current one handshakes, so outputs hold under stall
  always_comb begin
    st_n = st;
    len_n = len_q;
    num_n = num_q;
    gap_n = gap_q;
    gap_cnt_n = gap_cnt;
    pkt_cnt_n = pkt_cnt;
    done_n = done;
    stop_n = stop_pend | (stop & busy);
    load = 1'b0;
    beat_n = beat_q;
    np = pkt_cnt[15:0];
    vld_n = vld_q;
    case (st)
      IDLE: if (start) begin
        st_n = SEND;
        len_n = ln;
        num_n = cfg_num_pkts;
        gap_n = cfg_gap;
        pkt_cnt_n = '0;
        done_n = 1'b0;
        stop_n = 1'b0;
        load = 1'b1;
        beat_n = '0;
        np = '0;
      end
      SEND: if (vld_q && tx.ready) begin
        if (q.eop) begin
          pkt_cnt_n = pkt_inc;
          if ((num_q != '0 && pkt_inc == num_q) || stop_pend) begin
            st_n = FIN;
            vld_n = 1'b0;
          end else if (gap_q != '0) begin
            st_n = GAP;
            gap_cnt_n = gap_q;
            vld_n = 1'b0;
          end else begin
            load = 1'b1;
            beat_n = '0;
            np = pkt_inc[15:0];
          end
        end else begin
          load = 1'b1;
          beat_n = beat_q + 1'b1;
        end
      end
      GAP: if (gap_cnt == 8'd1) begin
        st_n = SEND;
        load = 1'b1;
        beat_n = '0;
      end else gap_cnt_n = gap_cnt - 8'd1;
      default: begin
        st_n = IDLE;
        done_n = 1'b1;
        stop_n = 1'b0;
      end
    endcase
    vld_n = load | vld_n;
  end
  // State and registered outputs; reset abandons any packet in flight
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      st <= IDLE;
      len_q <= '0;
      num_q <= '0;
      gap_q <= '0;
      gap_cnt <= '0;
      pkt_cnt <= '0;
      beat_q <= '0;
      done <= 1'b0;
      stop_pend <= 1'b0;
      vld_q <= 1'b0;
      q <= '0;
    end else begin
      st <= st_n;
      len_q <= len_n;
      num_q <= num_n;
      gap_q <= gap_n;
      gap_cnt <= gap_cnt_n;
      pkt_cnt <= pkt_cnt_n;
      beat_q <= beat_n;
      done <= done_n;
      stop_pend <= stop_n;
      vld_q <= vld_n;
      q <= q_n;
    end
endmodule

// File: tb/tb_pc_pkt_gen.sv
// tb_pc_pkt_gen: directed scenarios for the packet generator
module tb_pc_pkt_gen;
  import pc_pkg::*;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [13:0] cfg_len = '0;
  logic [31:0] cfg_num_pkts = '0;
  logic [7:0] cfg_gap = '0;
  logic busy, done;
  logic [31:0] pkt_cnt;
  pc_pkt_gen_if tx_if();
  pc_pkt_gen #(.LEN_W(14), .MIN_LEN(64), .MAX_LEN(9600)) dut (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .cfg_len(cfg_len),
    .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap), .busy(busy), .done(done),
    .pkt_cnt(pkt_cnt), .tx(tx_if)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  pc_beat_t beats[$];
  pc_beat_t ref_beats[$];
  int gaps[$];
  int viol;
  bit timed_out;

  function automatic logic [511:0] exp_data(input int p, input int b);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[511-32*i -: 32] = {16'(p), 8'(b), 8'(i)};
    return d;
  endfunction

  task automatic do_start(input int len, input int num, input int gap);
    @(negedge clk);
    cfg_len = 14'(len);
    cfg_num_pkts = num;
    cfg_gap = 8'(gap);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_len = 14'd1000;
    cfg_num_pkts = 32'd77;
    cfg_gap = 8'd9;
  endtask

  task automatic collect(input int max_cyc, input bit rnd, input int stop_pkt);
    pc_beat_t cur, prev;
    bit prev_stall = 0, seen_eop = 0;
    int idle = 0;
    prev = '0;
    beats.delete();
    gaps.delete();
    viol = 0;
    timed_out = 1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      cur = '{sop: tx_if.sop, eop: tx_if.eop, empty: tx_if.empty, data: tx_if.data};
      if (prev_stall && (!tx_if.valid || cur !== prev)) viol++;
      if (done) begin
        timed_out = 0;
        break;
      end
      stop = stop_pkt >= 0 && tx_if.valid && int'(cur.data[511:496]) == stop_pkt && cur.data[495:488] == 8'd1;
      tx_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!tx_if.valid && seen_eop) idle++;
      if (tx_if.valid && cur.sop && seen_eop) begin
        gaps.push_back(idle);
        seen_eop = 0;
      end
      if (tx_if.valid && tx_if.ready) begin
        beats.push_back(cur);
        if (cur.eop) begin
          seen_eop = 1;
          idle = 0;
        end
      end
      prev_stall = tx_if.valid && !tx_if.ready;
      prev = cur;
    end
    stop = 1'b0;
    tx_if.ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (tx_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", tx_if.valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    arst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got valid=%0b busy=%0b want 0 0", tx_if.valid, busy); end
  endtask

  task automatic test_single();
    do_start(64, 1, 0);
    @(negedge clk);
    total++; if ({tx_if.valid, tx_if.sop, tx_if.eop} !== 3'b111) begin bad++; $display("FAIL single_flags: got %b want 111", {tx_if.valid, tx_if.sop, tx_if.eop}); end
    total++; if (tx_if.empty !== 6'd0) begin bad++; $display("FAIL single_empty: got %0d want 0", tx_if.empty); end
    total++; if (tx_if.data[511:480] !== 32'h0) begin bad++; $display("FAIL single_lane0: got %h want 00000000", tx_if.data[511:480]); end
    total++; if (tx_if.data[31:0] !== 32'hF) begin bad++; $display("FAIL single_lane15: got %h want 0000000f", tx_if.data[31:0]); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
    @(negedge clk);
    total++; if (tx_if.valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_fin: got valid=%0b done=%0b want 0 0", tx_if.valid, done); end
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got done=%0b busy=%0b want 1 0", done, busy); end
  endtask

  task automatic test_gap();
    do_start(100, 3, 2);
    collect(60, 0, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL gap_timeout: got %0b want 0", timed_out); end
    total++; if (beats.size() !== 6) begin bad++; $display("FAIL gap_beats: got %0d want 6", beats.size()); end
    for (int k = 0; k < beats.size() && k < 6; k++) begin
      total++;
      if (beats[k] !== '{sop: k % 2 == 0, eop: k % 2 == 1, empty: (k % 2 == 1) ? 6'd28 : 6'd0, data: exp_data(k / 2, k % 2)}) begin
        bad++; $display("FAIL gap_beat%0d: got sop=%0b eop=%0b empty=%0d lane0=%h", k, beats[k].sop, beats[k].eop, beats[k].empty, beats[k].data[511:480]);
      end
    end
    total++; if (beats.size() == 6 && beats[5].data[511:480] !== 32'h00020100) begin bad++; $display("FAIL gap_p2b1_lane0: got %h want 00020100", beats[5].data[511:480]); end
    total++; if (gaps.size() !== 2) begin bad++; $display("FAIL gap_count: got %0d want 2", gaps.size()); end
    foreach (gaps[g]) begin
      total++; if (gaps[g] !== 2) begin bad++; $display("FAIL gap_idle%0d: got %0d want 2", g, gaps[g]); end
    end
    total++; if (pkt_cnt !== 32'd3) begin bad++; $display("FAIL gap_pkt_cnt: got %0d want 3", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    do_start(200, 2, 1);
    collect(100, 0, -1);
    ref_beats = beats;
    do_start(200, 2, 1);
    collect(400, 1, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %0b want 0", timed_out); end
    total++; if (viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", viol); end
    total++; if (beats.size() !== 8 || ref_beats.size() !== 8) begin bad++; $display("FAIL bp_beats: got %0d/%0d want 8/8", beats.size(), ref_beats.size()); end
    for (int k = 0; k < 8 && k < beats.size() && k < ref_beats.size(); k++) begin
      total++;
      if (beats[k] !== ref_beats[k] || beats[k] !== '{sop: k % 4 == 0, eop: k % 4 == 3, empty: (k % 4 == 3) ? 6'd56 : 6'd0, data: exp_data(k / 4, k % 4)}) begin
        bad++; $display("FAIL bp_beat%0d: got sop=%0b eop=%0b empty=%0d lane0=%h", k, beats[k].sop, beats[k].eop, beats[k].empty, beats[k].data[511:480]);
      end
    end
    total++; if (pkt_cnt !== 32'd2) begin bad++; $display("FAIL bp_pkt_cnt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_back_to_back_stop();
    do_start(192, 0, 0);
    collect(200, 0, 5);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL stop_timeout: got %0b want 0", timed_out); end
    total++; if (beats.size() !== 18) begin bad++; $display("FAIL stop_beats: got %0d want 18", beats.size()); end
    total++; if (beats.size() > 0 && (beats[beats.size()-1].eop !== 1'b1 || beats[beats.size()-1].data[511:480] !== 32'h00050200)) begin
      bad++; $display("FAIL stop_last: got eop=%0b lane0=%h want 1 00050200", beats[beats.size()-1].eop, beats[beats.size()-1].data[511:480]);
    end
    total++; if (gaps.size() !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", gaps.size()); end
    foreach (gaps[g]) begin
      total++; if (gaps[g] !== 0) begin bad++; $display("FAIL b2b_idle%0d: got %0d want 0", g, gaps[g]); end
    end
    total++; if (pkt_cnt !== 32'd6 || done !== 1'b1) begin bad++; $display("FAIL stop_status: got pkt_cnt=%0d done=%0b want 6 1", pkt_cnt, done); end
    repeat (5) @(negedge clk);
    total++; if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_quiet: got valid=%0b busy=%0b want 0 0", tx_if.valid, busy); end
  endtask

  task automatic test_clamp();
    do_start(10, 1, 0);
    collect(20, 0, -1);
    total++; if (beats.size() !== 1) begin bad++; $display("FAIL clamp_min_beats: got %0d want 1", beats.size()); end
    total++; if (beats.size() == 1 && {beats[0].sop, beats[0].eop, beats[0].empty} !== 8'b11_000000) begin bad++; $display("FAIL clamp_min_beat: got sop=%0b eop=%0b empty=%0d want 1 1 0", beats[0].sop, beats[0].eop, beats[0].empty); end
    do_start(16000, 1, 0);
    collect(200, 0, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL clamp_timeout: got %0b want 0", timed_out); end
    total++; if (beats.size() !== 150) begin bad++; $display("FAIL clamp_max_beats: got %0d want 150", beats.size()); end
    total++; if (beats.size() == 150 && (beats[148].eop !== 1'b0 || beats[149] !== '{sop: 1'b0, eop: 1'b1, empty: 6'd0, data: exp_data(0, 149)})) begin
      bad++; $display("FAIL clamp_max_last: got eop148=%0b eop=%0b empty=%0d lane0=%h want 0 1 0 00009500", beats[148].eop, beats[149].eop, beats[149].empty, beats[149].data[511:480]);
    end
  endtask

  task automatic test_async_reset();
    do_start(64, 0, 0);
    repeat (5) @(negedge clk);
    total++; if (tx_if.valid !== 1'b1 || pkt_cnt === 32'd0) begin bad++; $display("FAIL ar_running: got valid=%0b pkt_cnt=%0d want 1 nonzero", tx_if.valid, pkt_cnt); end
    #2 arst = 1'b1;
    #1;
    total++; if (tx_if.valid !== 1'b0 || tx_if.sop !== 1'b0 || tx_if.data !== '0) begin bad++; $display("FAIL ar_outputs: got valid=%0b sop=%0b lane0=%h want 0 0 0", tx_if.valid, tx_if.sop, tx_if.data[511:480]); end
    total++; if (busy !== 1'b0 || pkt_cnt !== 32'd0) begin bad++; $display("FAIL ar_status: got busy=%0b pkt_cnt=%0d want 0 0", busy, pkt_cnt); end
    @(negedge clk);
    arst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_idle: got valid=%0b busy=%0b want 0 0", tx_if.valid, busy); end
    do_start(64, 1, 0);
    @(negedge clk);
    total++; if (tx_if.valid !== 1'b1 || tx_if.sop !== 1'b1 || tx_if.data[511:480] !== 32'h0) begin bad++; $display("FAIL ar_restart: got valid=%0b sop=%0b lane0=%h want 1 1 00000000", tx_if.valid, tx_if.sop, tx_if.data[511:480]); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tx_if.ready = 1'b1;
    test_reset();
    test_single();
    test_gap();
    test_backpressure();
    test_back_to_back_stop();
    test_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
